// File: rtl/mem_stage.sv
// Memory stage: turns EX/MEM loads/stores into a single-outstanding bus request and registers the MEM/WB payload.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses bypass the bus and raise misalign for one cycle.
`ifndef BITWIDTH
`define BITWIDTH 32
`endif

module mem_stage (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`BITWIDTH-1:0] pcAddr,
    input  logic [4:0]           rdAddr,
    input  logic                 rwen,
    input  logic                 mwen,
    input  logic [1:0]           wbSel,
    input  logic [2:0]           lsWidth,
    input  logic [`BITWIDTH-1:0] result,
    input  logic                 pcSel,
    input  logic [`BITWIDTH-1:0] rs2Data,
    output logic                 busReq,
    output logic                 busWe,
    output logic [`BITWIDTH-1:0] busAddr,
    output logic [`BITWIDTH-1:0] busWdata,
    output logic [3:0]           busBe,
    input  logic [`BITWIDTH-1:0] busRdata,
    input  logic                 busAck,
    output logic                 stall,
    output logic [`BITWIDTH-1:0] pcAddrOut,
    output logic [4:0]           rdAddrOut,
    output logic                 rwenOut,
    output logic [1:0]           wbSelOut,
    output logic [`BITWIDTH-1:0] resultOut,
    output logic [`BITWIDTH-1:0] loadDataOut,
    output logic                 pcSelOut,
    output logic                 misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    logic                 is_load;
    logic                 is_mem;
    logic                 mis_acc;
    logic                 access;
    logic [3:0]           be_calc;
    logic [`BITWIDTH-1:0] wdata_calc;
    logic [`BITWIDTH-1:0] shifted;
    logic [`BITWIDTH-1:0] load_ext;

    logic [`BITWIDTH-1:0] lat_pc;
    logic [4:0]           lat_rd;
    logic                 lat_rwen;
    logic [1:0]           lat_wbsel;
    logic [`BITWIDTH-1:0] lat_result;
    logic                 lat_pcsel;
    logic [2:0]           lat_width;
    logic                 lat_load;

    assign is_load = (wbSel == 2'b01);
    assign is_mem  = is_load | mwen;

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis_acc = is_mem &&
                     (((lsWidth[1:0] == 2'b01) && result[0]) ||
                      (lsWidth[1] && (result[1:0] != 2'b00)));
`else
    assign mis_acc = 1'b0;
`endif

    assign access = is_mem & ~mis_acc;

    // Width code: low two bits give the size (00 byte, 01 half, else word); bit 2 selects zero-extension.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = rs2Data;
        case (lsWidth[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << result[1:0];
                wdata_calc = {4{rs2Data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << result[1:0];
                wdata_calc = {2{rs2Data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = busRdata >> {lat_result[1:0], 3'b000};
        load_ext = busRdata;
        case (lat_width)
            3'b000:  load_ext = {{(`BITWIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(`BITWIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(`BITWIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(`BITWIDTH-16){1'b0}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (busAck) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busReq      <= '0;
            busWe       <= '0;
            busAddr     <= '0;
            busWdata    <= '0;
            busBe       <= '0;
            pcAddrOut   <= '0;
            rdAddrOut   <= '0;
            rwenOut     <= '0;
            wbSelOut    <= '0;
            resultOut   <= '0;
            loadDataOut <= '0;
            pcSelOut    <= '0;
            misalign    <= '0;
            lat_pc      <= '0;
            lat_rd      <= '0;
            lat_rwen    <= '0;
            lat_wbsel   <= '0;
            lat_result  <= '0;
            lat_pcsel   <= '0;
            lat_width   <= '0;
            lat_load    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        lat_pc     <= pcAddr;
                        lat_rd     <= rdAddr;
                        lat_rwen   <= rwen;
                        lat_wbsel  <= wbSel;
                        lat_result <= result;
                        lat_pcsel  <= pcSel;
                        lat_width  <= lsWidth;
                        lat_load   <= is_load;
                        busReq     <= 1'b1;
                        busWe      <= mwen;
                        busAddr    <= {result[`BITWIDTH-1:2], 2'b00};
                        busBe      <= be_calc;
                        busWdata   <= wdata_calc;
                        rwenOut    <= 1'b0;
                        pcSelOut   <= 1'b0;
                        misalign   <= 1'b0;
                    end else begin
                        pcAddrOut   <= pcAddr;
                        rdAddrOut   <= rdAddr;
                        rwenOut     <= rwen & ~mis_acc;
                        wbSelOut    <= wbSel;
                        resultOut   <= result;
                        loadDataOut <= '0;
                        pcSelOut    <= pcSel;
                        misalign    <= mis_acc;
                    end
                end
                BUSY: begin
                    if (busAck) begin
                        busReq      <= 1'b0;
                        busWe       <= 1'b0;
                        busAddr     <= '0;
                        busBe       <= '0;
                        busWdata    <= '0;
                        pcAddrOut   <= lat_pc;
                        rdAddrOut   <= lat_rd;
                        rwenOut     <= lat_rwen;
                        wbSelOut    <= lat_wbsel;
                        resultOut   <= lat_result;
                        loadDataOut <= lat_load ? load_ext : '0;
                        pcSelOut    <= lat_pcsel;
                        misalign    <= 1'b0;
                    end else begin
                        rwenOut  <= 1'b0;
                        pcSelOut <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model, per-cycle compare, directed pins.
`timescale 1ns/1ps

module tb_mem_stage;

    logic        clk, rst;
    logic [31:0] pcAddr, result, rs2Data, busRdata;
    logic [4:0]  rdAddr;
    logic        rwen, mwen, pcSel, busAck;
    logic [1:0]  wbSel;
    logic [2:0]  lsWidth;
    logic        busReq, busWe, stall, rwenOut, pcSelOut, misalign;
    logic [31:0] busAddr, busWdata, pcAddrOut, resultOut, loadDataOut;
    logic [3:0]  busBe;
    logic [4:0]  rdAddrOut;
    logic [1:0]  wbSelOut;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .pcAddr(pcAddr), .rdAddr(rdAddr), .rwen(rwen), .mwen(mwen), .wbSel(wbSel),
        .lsWidth(lsWidth), .result(result), .pcSel(pcSel), .rs2Data(rs2Data),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata), .busBe(busBe),
        .busRdata(busRdata), .busAck(busAck), .stall(stall),
        .pcAddrOut(pcAddrOut), .rdAddrOut(rdAddrOut), .rwenOut(rwenOut), .wbSelOut(wbSelOut),
        .resultOut(resultOut), .loadDataOut(loadDataOut), .pcSelOut(pcSelOut), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rwen;
        logic [1:0]  wbsel;
        logic [31:0] res;
        logic [31:0] ld;
        logic        pcsel;
        logic        mis;
    } out_t;

    out_t        exp_o;
    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    bit          chk_on;

    int vectors = 0;
    int miscompares = 0;

    int unsigned obs_stall;
    bit          obs_req, obs_rwen, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("busReq", {31'b0, busReq}, {31'b0, exp_req});
            if (exp_req) begin
                chk("busWe", {31'b0, busWe}, {31'b0, exp_we});
                chk("busAddr", busAddr, exp_addr);
                chk("busBe", {28'b0, busBe}, {28'b0, exp_be});
                chk("busWdata", busWdata, exp_wdata);
            end
            chk("pcAddrOut", pcAddrOut, exp_o.pc);
            chk("rdAddrOut", {27'b0, rdAddrOut}, {27'b0, exp_o.rd});
            chk("rwenOut", {31'b0, rwenOut}, {31'b0, exp_o.rwen});
            chk("wbSelOut", {30'b0, wbSelOut}, {30'b0, exp_o.wbsel});
            chk("resultOut", resultOut, exp_o.res);
            chk("loadDataOut", loadDataOut, exp_o.ld);
            chk("pcSelOut", {31'b0, pcSelOut}, {31'b0, exp_o.pcsel});
            chk("misalign", {31'b0, misalign}, {31'b0, exp_o.mis});
        end
    end

    function automatic logic [3:0] model_be(input logic [2:0] w, input logic [1:0] a);
        int unsigned m;
        case (w[1:0])
            2'b00:   m = 1;
            2'b01:   m = 3;
            default: return 4'hF;
        endcase
        m = m << a;
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] w, input logic [31:0] d);
        case (w[1:0])
            2'b00:   return {24'b0, d[7:0]} * 32'h0101_0101;
            2'b01:   return {16'b0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] w, input logic [1:0] a, input logic [31:0] d);
        int unsigned v;
        v = d / (32'd1 << (8 * a));
        case (w)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input bit busy);
        #2;
        if (stall) obs_stall++;
        if (busy && rwenOut) obs_rwen = 1;
        if (busReq) begin
            obs_req   = 1;
            obs_we    = busWe;
            obs_addr  = busAddr;
            obs_be    = busBe;
            obs_wdata = busWdata;
        end
    endtask

    task automatic nop_inputs();
        pcAddr = '0; rdAddr = '0; rwen = 0; mwen = 0; wbSel = '0;
        lsWidth = '0; result = '0; pcSel = 0; rs2Data = '0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic rw, input logic mw,
                         input logic [1:0] wbs, input logic [2:0] w, input logic [31:0] res,
                         input logic ps, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int unsigned lat);
        bit ld, acc, mis;
        ld  = (wbs == 2'b01);
        acc = ld || mw;
        mis = 0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (acc && ((w[1:0] == 2'b01 && res[0]) || (w[1:0] >= 2'b10 && res[1:0] != 2'b00))) mis = 1;
`endif
        obs_stall = 0; obs_req = 0; obs_rwen = 0; obs_we = 0;
        obs_addr = '0; obs_be = '0; obs_wdata = '0;
        pcAddr = pc; rdAddr = rd; rwen = rw; mwen = mw; wbSel = wbs;
        lsWidth = w; result = res; pcSel = ps; rs2Data = rs2;
        busAck = 1'($urandom_range(0, 1));
        busRdata = $urandom;
        if (acc && !mis) begin
            exp_stall = 1; exp_req = 0;
            sample(0);
            tick();
            exp_o.rwen = 0; exp_o.pcsel = 0; exp_o.mis = 0;
            exp_req = 1; exp_we = mw;
            exp_addr  = {res[31:2], 2'b00};
            exp_be    = model_be(w, res[1:0]);
            exp_wdata = model_wd(w, rs2);
            // Inputs wander while the access is outstanding; the stage must ignore them.
            pcAddr = $urandom; rdAddr = 5'($urandom); rwen = 1'($urandom); mwen = 1'($urandom);
            wbSel = 2'($urandom); lsWidth = 3'($urandom); result = $urandom; pcSel = 1'($urandom);
            rs2Data = $urandom;
            for (int unsigned k = 0; k <= lat; k++) begin
                busAck   = (k == lat);
                busRdata = (k == lat) ? rdata : $urandom;
                sample(1);
                tick();
            end
            busAck = 0;
            exp_req = 0;
            exp_o = '{pc: pc, rd: rd, rwen: rw, wbsel: wbs, res: res,
                      ld: ld ? model_ld(w, res[1:0], rdata) : 32'h0, pcsel: ps, mis: 1'b0};
            nop_inputs();
            exp_stall = 0;
        end else begin
            exp_stall = 0; exp_req = 0;
            sample(0);
            tick();
            busAck = 0;
            exp_o = '{pc: pc, rd: rd, rwen: rw && !mis, wbsel: wbs, res: res,
                      ld: 32'h0, pcsel: ps, mis: mis};
        end
    endtask

    initial begin
        logic [2:0]  w;
        logic [31:0] addr;
        int unsigned kind;
        logic [2:0]  ld_widths [5];
        ld_widths = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1; busAck = 0; busRdata = '0;
        nop_inputs();
        exp_o = '0; exp_stall = 0; exp_req = 0; exp_we = 0;
        exp_addr = '0; exp_be = '0; exp_wdata = '0;
        chk_on = 1;
        #2;
        chk("reset busReq", {31'b0, busReq}, 32'h0);
        chk("reset resultOut", resultOut, 32'h0);
        tick(); tick();
        rst = 0;

        // ALU pass-through
        issue(32'h40, 5'd3, 1, 0, 2'b00, 3'b010, 32'h1234, 0, 32'h0, 32'h0, 0);
        chk("alu resultOut", resultOut, 32'h1234);
        chk("alu rwenOut", {31'b0, rwenOut}, 32'h1);
        chk("alu busReq", {31'b0, busReq}, 32'h0);
        chk("alu stall", {31'b0, stall}, 32'h0);

        // LB at lane 3, ack one cycle after request
        issue(32'h44, 5'd5, 1, 0, 2'b01, 3'b000, 32'h103, 0, 32'h0, 32'h8011_2233, 1);
        chk("lb busBe", {28'b0, obs_be}, 32'h8);
        chk("lb loadDataOut", loadDataOut, 32'hFFFF_FF80);
        chk("lb rwenOut", {31'b0, rwenOut}, 32'h1);
        chk("lb stall cycles", obs_stall, 32'd3);

        // SH at lane 2, ack three cycles after request
        issue(32'h48, 5'd0, 0, 1, 2'b00, 3'b001, 32'h202, 0, 32'h0000_BEEF, 32'h0, 3);
        chk("sh busWdata", obs_wdata, 32'hBEEF_BEEF);
        chk("sh busBe", {28'b0, obs_be}, 32'hC);
        chk("sh busWe", {31'b0, obs_we}, 32'h1);
        chk("sh stall cycles", obs_stall, 32'd5);
        chk("sh rwen during busy", {31'b0, obs_rwen}, 32'h0);
        chk("sh rwenOut", {31'b0, rwenOut}, 32'h0);
        chk("sh loadDataOut", loadDataOut, 32'h0);

        // LHU at lane 2
        issue(32'h4C, 5'd7, 1, 0, 2'b01, 3'b101, 32'h302, 1, 32'h0, 32'hF00D_0000, 0);
        chk("lhu loadDataOut", loadDataOut, 32'h0000_F00D);
        chk("lhu stall cycles", obs_stall, 32'd2);

        // LW misaligned
        issue(32'h50, 5'd9, 1, 0, 2'b01, 3'b010, 32'h401, 0, 32'h0, 32'hCAFE_F00D, 1);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis busReq seen", {31'b0, obs_req}, 32'h0);
        chk("mis misalign", {31'b0, misalign}, 32'h1);
        chk("mis rwenOut", {31'b0, rwenOut}, 32'h0);
        issue(32'h54, 5'd1, 0, 0, 2'b00, 3'b000, 32'h0, 0, 32'h0, 32'h0, 0);
        chk("mis one cycle", {31'b0, misalign}, 32'h0);
`else
        chk("mis busAddr", obs_addr, 32'h400);
        chk("mis busBe", {28'b0, obs_be}, 32'hF);
        chk("mis loadDataOut", loadDataOut, 32'hCAFE_F00D);
        chk("mis misalign", {31'b0, misalign}, 32'h0);
`endif

        // Reset during BUSY, stray ack after release
        chk_on = 0;
        pcAddr = 32'h60; rdAddr = 5'd4; rwen = 1; mwen = 0; wbSel = 2'b01;
        lsWidth = 3'b010; result = 32'h500; pcSel = 1; rs2Data = '0;
        tick();
        #2;
        chk("busy before reset", {31'b0, busReq}, 32'h1);
        rst = 1;
        nop_inputs();
        #2;
        chk("async reset busReq", {31'b0, busReq}, 32'h0);
        chk("async reset stall", {31'b0, stall}, 32'h0);
        tick();
        rst = 0;
        tick();
        busAck = 1; busRdata = 32'h1234_5678;
        tick();
        busAck = 0;
        #2;
        chk("post-reset busReq", {31'b0, busReq}, 32'h0);
        chk("post-reset stall", {31'b0, stall}, 32'h0);
        chk("post-reset pcAddrOut", pcAddrOut, 32'h0);
        chk("post-reset rwenOut", {31'b0, rwenOut}, 32'h0);
        chk("post-reset loadDataOut", loadDataOut, 32'h0);
        chk("post-reset busBe", {28'b0, busBe}, 32'h0);
        exp_o = '0; exp_stall = 0; exp_req = 0;
        chk_on = 1;

        // Randomised mix
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            addr = $urandom;
            if (kind == 0) begin
                issue($urandom, 5'($urandom), 1'($urandom), 0, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10,
                      3'($urandom), addr, 1'($urandom), $urandom, $urandom, 0);
            end else if (kind == 1) begin
                w = ld_widths[$urandom_range(0, 4)];
                if (w[1:0] == 2'b01) addr[0] = 1'b0;
                if (w[1:0] == 2'b10) addr[1:0] = 2'b00;
                issue($urandom, 5'($urandom), 1'($urandom), 0, 2'b01, w, addr, 1'($urandom),
                      $urandom, $urandom, $urandom_range(0, 4));
            end else begin
                w = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 3) != 0) begin
                    if (w[1:0] == 2'b01) addr[0] = 1'b0;
                    if (w[1:0] == 2'b10) addr[1:0] = 2'b00;
                end
                issue($urandom, 5'($urandom), 1'($urandom), 1, 2'b00, w, addr, 1'($urandom),
                      $urandom, $urandom, $urandom_range(0, 4));
            end
        end

        tick();
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
